// File: rtl/regfile_wr_arbiter.sv
// Two-requester write arbiter feeding a single register-file write port through a one-entry output slot.
// Define REGFILE_WR_ARB_FIXED_PRIO_EN for fixed req0 priority; round-robin otherwise.
module regfile_wr_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              wr_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_src,
    output logic [7:0]        stall_cnt
);

    typedef enum logic [1:0] {IDLE, WRITE, STALL} state_t;

    localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              src_q, src_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              slot_busy;
    logic              slot_open;
    logic              xfer;
    logic              gnt1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifndef REGFILE_WR_ARB_FIXED_PRIO_EN
    // ptr_q names the requester favoured on the next contention.
    logic ptr_q, ptr_d;
`endif

    assign slot_busy = (state_q != IDLE);
    assign slot_open = !slot_busy || !wr_stall;
    assign xfer      = !reset && slot_open && (req0_valid || req1_valid);

`ifdef REGFILE_WR_ARB_FIXED_PRIO_EN
    assign gnt1 = !req0_valid;
`else
    assign gnt1 = req1_valid && (!req0_valid || ptr_q);
`endif

    assign req0_ready = xfer && !gnt1;
    assign req1_ready = xfer && gnt1;
    assign sel_addr   = gnt1 ? req1_addr : req0_addr;
    assign sel_data   = gnt1 ? req1_data : req0_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
`ifndef REGFILE_WR_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
        if (xfer) ptr_d = !gnt1;
`endif
        if (slot_busy && wr_stall) begin
            state_d = STALL;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (xfer && (sel_addr != ZERO_REG)) begin
            state_d = WRITE;
            addr_d  = sel_addr;
            data_d  = sel_data;
            src_d   = gnt1;
        end else begin
            // Writes to the zero register are consumed without occupying the slot.
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            src_q   <= 1'b0;
            cnt_q   <= 8'd0;
`ifndef REGFILE_WR_ARB_FIXED_PRIO_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
`ifndef REGFILE_WR_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign wr_en     = slot_busy;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign wr_src    = src_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: transaction-level model plus directed and random stimulus.
module tb_regfile_wr_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wr_stall;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_src;
    logic [7:0]    stall_cnt;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_src(wr_src), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            src;
    } txn_t;

    txn_t slot[$];      // pending write presented to the register file
    int   m_last = 1;   // requester granted last; 1 means req0 is favoured
    int   m_cnt  = 0;
    int   m_win  = -1;  // requester the model grants this cycle, -1 for none

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and compare every DUT output against the model.
    task automatic drive(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit st, input bit rs);
        bit open;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        wr_stall = st; reset = rs;
        #2;
        open  = !rs && (slot.size() == 0 || !st);
        m_win = -1;
        if (open) begin
            if (v0 && v1) begin
`ifdef REGFILE_WR_ARB_FIXED_PRIO_EN
                m_win = 0;
`else
                m_win = (m_last == 0) ? 1 : 0;
`endif
            end else if (v0) m_win = 0;
            else if (v1) m_win = 1;
        end
        check("req0_ready", req0_ready, (m_win == 0));
        check("req1_ready", req1_ready, (m_win == 1));
        check("wr_en", wr_en, (slot.size() != 0));
        check("stall_cnt", stall_cnt, m_cnt);
        if (slot.size() != 0) begin
            check("wr_addr", wr_addr, slot[0].addr);
            check("wr_data", wr_data, slot[0].data);
            check("wr_src", wr_src, slot[0].src);
        end
    endtask

    // Advance the model by the cycle just driven, then cross the clock edge.
    task automatic tick();
        txn_t t;
        if (reset) begin
            slot.delete();
            m_last = 1;
            m_cnt  = 0;
        end else begin
            if (slot.size() != 0 && wr_stall) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            if (slot.size() != 0 && !wr_stall) void'(slot.pop_front());
            if (m_win >= 0) begin
                m_last = m_win;
                t.addr = m_win ? req1_addr : req0_addr;
                t.data = m_win ? req1_data : req0_data;
                t.src  = (m_win == 1);
                if (t.addr != 5'd31) slot.push_back(t);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit st);
        drive(0, 0, 0, 0, 0, 0, st, 0);
        tick();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    int exp_g[4];

    initial begin
        reset = 1'b1; wr_stall = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        @(posedge clk);
        #1;

        // Reset with both valid, then first grant after reset.
        drive(1, 5'd3, 64'h11, 1, 5'd6, 64'h22, 0, 1);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);
        tick();
        drive(1, 5'd3, 64'h11, 1, 5'd6, 64'h22, 0, 1);
        tick();
        drive(1, 5'd3, 64'h11, 1, 5'd6, 64'h22, 0, 0);
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_cnt", stall_cnt, 0);
        check("post_rst_addr", wr_addr, 0);
        check("post_rst_src", wr_src, 0);
        check("first_grant0", req0_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("first_wr_en", wr_en, 1);
        check("first_wr_addr", wr_addr, 3);
        check("first_wr_src", wr_src, 0);
        tick();

        // Continuous contention on addresses 4 and 5.
`ifdef REGFILE_WR_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'd4, 64'(i), 1, 5'd5, 64'(i + 100), 0, 0);
            check("contend_grant1", req1_ready, exp_g[i]);
            if (i > 0) check("contend_addr", wr_addr, exp_g[i-1] ? 5 : 4);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("contend_addr_last", wr_addr, exp_g[3] ? 5 : 4);
        tick();

        // Zero-register write consumes the grant without a write pulse.
        do_reset();
        drive(0, 0, 0, 1, 5'd31, 64'hDEAD, 0, 0);
        check("x31_ready1", req1_ready, 1);
        tick();
        drive(1, 5'd2, 64'h2, 1, 5'd8, 64'h8, 0, 0);
        check("x31_no_wr_en", wr_en, 0);
        check("x31_next_grant0", req0_ready, 1);
        tick();
        idle(0);

        // Stall holds the slot, queued req0 accepted on release.
        do_reset();
        drive(1, 5'd7, 64'h77, 0, 0, 0, 0, 0);
        check("stall_acc7", req0_ready, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd9, 64'h99, 0, 0, 0, 1, 0);
            check("stall_rdy0", req0_ready, 0);
            check("stall_hold_addr", wr_addr, 7);
            tick();
        end
        drive(1, 5'd9, 64'h99, 0, 0, 0, 0, 0);
        check("stall_cnt3", stall_cnt, 3);
        check("release_acc", req0_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("release_addr9", wr_addr, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_idle", wr_en, 0);
        tick();

        // Saturation of the stall counter.
        do_reset();
        drive(1, 5'd7, 64'h77, 0, 0, 0, 0, 0);
        tick();
        repeat (300) idle(1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        check("stall_sat", stall_cnt, 255);
        tick();
        idle(0);

        // Reset during STALL discards the pending write.
        do_reset();
        drive(1, 5'd7, 64'h77, 0, 0, 0, 0, 0);
        tick();
        idle(1);
        idle(1);
        drive(1, 5'd1, 64'h1, 1, 5'd2, 64'h2, 1, 1);
        check("rst_stall_rdy0", req0_ready, 0);
        check("rst_stall_rdy1", req1_ready, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_stall_wr_en", wr_en, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        tick();
        repeat (3) idle(0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1), AW'($urandom_range(0, 31)), {$urandom, $urandom},
                  $urandom_range(0, 1), AW'($urandom_range(0, 31)), {$urandom, $urandom},
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
